dir_offset_pipe: RTL



---
 rtl/dir_offset_pkg.sv | 32 +++
 rtl/dir_offset_lane.sv | 15 +
 rtl/dir_offset_pipe.sv | 104 ++++++++++
 3 files changed

// File: rtl/dir_offset_pkg.sv
// dir_offset_pkg: shared defaults and the per-lane offset arithmetic for
// dir_offset_pipe. offset_calc works on 32-bit containers with a runtime width
// so one function serves every DW up to 32; callers truncate to DW bits.
package dir_offset_pkg;

  localparam int AW_D     = 8;
  localparam int PW_D     = 4;
  localparam int DW_D     = 5;
  localparam int NCH_D    = 1;
  localparam int NSEL_D   = 4;
  localparam int CENTER_D = 8;
  localparam int MAXW     = 32;

  // c and idx are zero-extended and both below 2^dw.
  // abs=0: (c - idx) mod 2^dw. abs=1: |c - idx| clamped to 2^dw - 1.
  function automatic logic [MAXW-1:0] offset_calc(input logic [MAXW-1:0] c,
                                                  input logic [MAXW-1:0] idx,
                                                  input logic            abs,
                                                  input int              dw);
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] d;
    mask = (dw >= MAXW) ? '1 : (({{(MAXW-1){1'b0}}, 1'b1} << dw) - 1);
    if (abs) begin
      d = (c >= idx) ? (c - idx) : (idx - c);
      if (d > mask) d = mask;
    end else begin
      d = (c - idx) & mask;
    end
    return d;
  endfunction

endpackage

// File: rtl/dir_offset_lane.sv
// dir_offset_lane: combinational offset for one lane.
//   idx [PW] bin index, c [DW] centre, abs mode select -> off [DW].
module dir_offset_lane import dir_offset_pkg::*; #(
  parameter int PW = PW_D,
  parameter int DW = DW_D
) (
  input  logic [PW-1:0] idx,
  input  logic [DW-1:0] c,
  input  logic          abs,
  output logic [DW-1:0] off
);

  assign off = DW'(offset_calc(MAXW'(c), MAXW'(idx), abs, DW));

endmodule

// File: rtl/dir_offset_pipe.sv
// dir_offset_pipe: two-stage direction-offset pipeline with programmable
// centre registers and valid/ready on both sides.
//   cfg_we/cfg_idx/cfg_data : centre register write port
//   in_valid/in_ready       : input handshake; in_addr (NCH lanes of AW),
//                             in_sel (centre index), in_abs (mode)
//   out_valid/out_ready     : output handshake; out_off (NCH lanes of DW)
// S1 captures idx/centre/mode, S2 captures the computed offsets.
module dir_offset_pipe import dir_offset_pkg::*; #(
  parameter  int AW     = AW_D,
  parameter  int PW     = PW_D,
  parameter  int DW     = DW_D,
  parameter  int NCH    = NCH_D,
  parameter  int NSEL   = NSEL_D,
  parameter  int CENTER = CENTER_D,
  localparam int SW     = (NSEL > 1) ? $clog2(NSEL) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [SW-1:0]     cfg_idx,
  input  logic [DW-1:0]     cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*AW-1:0] in_addr,
  input  logic [SW-1:0]     in_sel,
  input  logic              in_abs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*DW-1:0] out_off
);

  localparam int            STAGES = 2;
  localparam logic [DW-1:0] CRST   = DW'(CENTER);

  logic [NSEL-1:0][DW-1:0] ctr;
  logic [DW-1:0]           csel;
  logic [STAGES:1]         vld_pipe;
  logic [NCH-1:0][PW-1:0]  a_idx;
  logic [NCH-1:0][PW-1:0]  s1_idx;
  logic [DW-1:0]           s1_c;
  logic                    s1_abs;
  logic [NCH-1:0][DW-1:0]  lane_off;
  logic [NCH-1:0][DW-1:0]  s2_off;
  logic                    adv;
  logic                    unused_addr;

  // Address bits above PW never matter (the index wraps on the bin period).
  assign unused_addr = ^in_addr;

  assign out_valid = vld_pipe[2];
  assign adv       = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || adv;
  assign out_off   = s2_off;

  // Out-of-range selector falls back to entry 0.
  always_comb begin
    csel = ctr[0];
    if (32'(in_sel) < 32'(NSEL)) csel = ctr[in_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= {NSEL{CRST}};
    end else if (cfg_we && (32'(cfg_idx) < 32'(NSEL))) begin
      ctr[cfg_idx] <= cfg_data;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    assign a_idx[k] = in_addr[k*AW +: PW];
    dir_offset_lane #(.PW(PW), .DW(DW)) u_lane (
      .idx (s1_idx[k]),
      .c   (s1_c),
      .abs (s1_abs),
      .off (lane_off[k])
    );
  end

  // Centre is captured into S1, so later cfg writes never touch in-flight work;
  // a same-cycle write is seen only by the next transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_idx   <= '0;
      s1_c     <= '0;
      s1_abs   <= 1'b0;
      s2_off   <= '0;
    end else begin
      if (in_ready) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1_idx <= a_idx;
          s1_c   <= csel;
          s1_abs <= in_abs;
        end
      end
      if (adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_off <= lane_off;
      end
    end
  end

endmodule
